exec_controller: RTL and testbench

EXEC_CONTROLLER -- requirements
Module: exec_controller

---
 rtl/exec_controller.sv | 174 +++++++++++++++++
 tb/tb_exec_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_controller.sv
// exec_controller: run/step/drain control for a simple pipelined core.
//
// The controller gates the pipeline through o_valid. A run command keeps the
// pipeline flowing until the fetch stage reports a HALT opcode. After that the
// pipeline drains for PIPE_DEPTH-1 more cycles, o_done pulses and the sticky
// halted flag is set. Step commands advance the pipeline one cycle at a time.
// A HALT seen while stepping is remembered, and the drain is then counted
// down by the following steps.
//
// Ports
//   i_clock         clock; every state update happens on the rising edge
//   i_reset         synchronous, active-high reset
//   i_cmd_run       pulse: start continuous execution (IDLE, not halted)
//   i_cmd_step      pulse: execute one pipeline cycle (IDLE, not halted)
//   i_cmd_abort     pulse: return to IDLE from any state, no o_done
//   i_cmd_clear     pulse: clear halted flag and cycle counter (IDLE only)
//   i_halt_fetched  fetch stage holds HALT; looked at only in RUN and STEP
//   o_valid         pipeline enable (RUN, STEP, DRAIN)
//   o_busy          controller busy (RUN, STEP, DRAIN)
//   o_done          one-cycle pulse in DONE
//   o_halted        sticky program-finished flag
//   o_cycle_count   saturating count of cycles with o_valid=1
//   o_state         IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4
//
// Handshake: there is no valid/ready pair here. Commands are single-cycle
// pulses that are acted on at the rising edge where they are high, and
// o_valid is a pure function of the current state with no added latency.
module exec_controller #(
  parameter int NB_DATA    = 32,
  parameter int PIPE_DEPTH = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_cmd_run,
  input  logic               i_cmd_step,
  input  logic               i_cmd_abort,
  input  logic               i_cmd_clear,
  input  logic               i_halt_fetched,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_halted,
  output logic [NB_DATA-1:0] o_cycle_count,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Wide enough to hold PIPE_DEPTH-1.
  localparam int CW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [CW-1:0]      DRAIN_LOAD = CW'(PIPE_DEPTH - 1);
  localparam logic [NB_DATA-1:0] CNT_MAX    = '1;

  state_t             state_q, state_d;
  logic [CW-1:0]      drain_cnt_q, drain_cnt_d;
  logic               pend_q, pend_d;      // step-mode drain in progress
  logic               halted_q, halted_d;
  logic [NB_DATA-1:0] cycles_q, cycles_d;
  logic               valid;

  assign valid = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pend_d      = pend_q;
    halted_d    = halted_q;
    cycles_d    = cycles_q;

    // The cycle in which abort arrives is still a valid cycle and is counted.
    if (valid && (cycles_q != CNT_MAX)) begin
      cycles_d = cycles_q + 1'b1;
    end

    if (i_cmd_abort) begin
      state_d     = S_IDLE;
      drain_cnt_d = '0;
      pend_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_cmd_clear) begin
            halted_d = 1'b0;
            cycles_d = '0;
            pend_d   = 1'b0;
          end else if (i_cmd_run && !halted_q) begin
            state_d = S_RUN;
          end else if (i_cmd_step && !halted_q) begin
            state_d = S_STEP;
          end
        end
        S_RUN: begin
          if (i_halt_fetched) begin
            if (PIPE_DEPTH == 1) begin
              state_d = S_DONE;
            end else begin
              state_d     = S_DRAIN;
              drain_cnt_d = DRAIN_LOAD;
            end
          end
        end
        S_STEP: begin
          state_d = S_IDLE;
          if (pend_q) begin
            // Once HALT has been seen, steps only count the drain down.
            if (drain_cnt_q <= 1) begin
              state_d     = S_DONE;
              pend_d      = 1'b0;
              drain_cnt_d = '0;
            end else begin
              drain_cnt_d = drain_cnt_q - 1'b1;
            end
          end else if (i_halt_fetched) begin
            if (PIPE_DEPTH == 1) begin
              state_d = S_DONE;
            end else begin
              pend_d      = 1'b1;
              drain_cnt_d = DRAIN_LOAD;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q <= 1) begin
            state_d     = S_DONE;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Halted becomes visible in the same cycle as o_done.
    if (state_d == S_DONE) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      pend_q      <= 1'b0;
      halted_q    <= 1'b0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      pend_q      <= pend_d;
      halted_q    <= halted_d;
      cycles_q    <= cycles_d;
    end
  end

  assign o_valid       = valid;
  assign o_busy        = valid;
  assign o_done        = (state_q == S_DONE);
  assign o_halted      = halted_q;
  assign o_cycle_count = cycles_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_exec_controller.sv
// Bench for exec_controller. Stimulus tasks issue command sequences and push
// the expected valid-burst lengths and done-time cycle counts into queues; a
// monitor on the falling edge pops and compares whenever the DUT ends a valid
// burst or pulses o_done.
module tb_exec_controller;

  localparam int NB = 32;
  localparam int D  = 5;

  logic          clk = 1'b0;
  logic          rst, run, step, abort, clr, halt;
  logic          o_valid, o_busy, o_done, o_halted;
  logic [NB-1:0] o_cycle_count;
  logic [2:0]    o_state;

  always #5 clk = ~clk;

  exec_controller #(.NB_DATA(NB), .PIPE_DEPTH(D)) dut (
    .i_clock(clk), .i_reset(rst), .i_cmd_run(run), .i_cmd_step(step),
    .i_cmd_abort(abort), .i_cmd_clear(clr), .i_halt_fetched(halt),
    .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done), .o_halted(o_halted),
    .o_cycle_count(o_cycle_count), .o_state(o_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [NB-1:0] exp_q[$];   // expected o_cycle_count at each o_done pulse
  int            burst_q[$]; // expected length of each o_valid burst

  // Reference model: plain program-level bookkeeping.
  logic [NB-1:0] m_count;
  bit            m_halted;
  bit            m_pend;
  int            m_left;

  bit mon_en    = 1'b0;
  int burst_len = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_state"}, o_state, 3'd0);
    check({tag, "_count"}, o_cycle_count, m_count);
    check({tag, "_halted"}, o_halted, m_halted);
  endtask

  // Monitor.
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy_eq_valid", o_busy, o_valid);
      check("valid_vs_state", o_valid, (o_state == 3'd1 || o_state == 3'd2 || o_state == 3'd3));
      if (o_valid === 1'b1) begin
        burst_len++;
      end else if (burst_len > 0) begin
        if (burst_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_burst: got length %0d expected none", burst_len);
        end else begin
          check("burst_len", burst_len, burst_q.pop_front());
        end
        burst_len = 0;
      end
      if (o_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got o_done=1 expected 0 at %0t", $time);
        end else begin
          check("done_count", o_cycle_count, exp_q.pop_front());
          check("done_halted", o_halted, 1'b1);
        end
      end
    end
  end

  // Run until HALT on the k-th valid cycle, then drain and finish.
  task automatic run_job(input int k, input bit with_step);
    m_count  = m_count + NB'(k + D - 1);
    m_halted = 1'b1;
    burst_q.push_back(k + D - 1);
    exp_q.push_back(m_count);
    run = 1'b1; step = with_step; cyc(); run = 1'b0; step = 1'b0;
    for (int j = 1; j <= k; j++) begin
      halt = (j == k); cyc();
    end
    // HALT is ignored while draining and in DONE.
    repeat (D - 1) begin halt = 1'($urandom_range(0, 1)); cyc(); end
    halt = 1'($urandom_range(0, 1)); cyc();
    halt = 1'b0;
    idle_checks("run_job");
  endtask

  task automatic step_once(input bit h);
    bit done_exp = 1'b0;
    if (!m_halted) begin
      burst_q.push_back(1);
      m_count = m_count + 1;
      if (m_pend) begin
        if (m_left <= 1) begin done_exp = 1'b1; m_pend = 1'b0; m_left = 0; end
        else m_left--;
      end else if (h) begin
        m_pend = 1'b1; m_left = D - 1;
      end
      if (done_exp) begin m_halted = 1'b1; exp_q.push_back(m_count); end
    end
    step = 1'b1; cyc(); step = 1'b0;
    halt = h; cyc(); halt = 1'b0;
    if (done_exp) cyc();
    repeat (2) begin halt = 1'($urandom_range(0, 1)); cyc(); end
    halt = 1'b0;
    idle_checks("step");
  endtask

  // Abort during the n-th valid cycle of a run.
  task automatic abort_run(input int n);
    burst_q.push_back(n);
    m_count = m_count + NB'(n);
    m_pend  = 1'b0;
    run = 1'b1; cyc(); run = 1'b0;
    for (int j = 1; j <= n; j++) begin
      halt = 1'b0; abort = (j == n); cyc();
    end
    abort = 1'b0;
    idle_checks("abort");
  endtask

  task automatic clear_cmd(input bit with_run);
    clr = 1'b1; run = with_run; cyc(); clr = 1'b0; run = 1'b0;
    m_count = '0; m_halted = 1'b0; m_pend = 1'b0;
    idle_checks("clear");
  endtask

  task automatic blocked_cmds();
    run = 1'b1; cyc(); run = 1'b0;
    step = 1'b1; cyc(); step = 1'b0;
    cyc();
    idle_checks("blocked");
  endtask

  task automatic priority_test();
    run = 1'b1; step = 1'b1; abort = 1'b1; cyc();
    run = 1'b0; step = 1'b0; abort = 1'b0;
    m_pend = 1'b0;
    check("prio_valid", o_valid, 1'b0);
    idle_checks("prio");
  endtask

  // Reset lands on the 2nd drain cycle together with a run command.
  task automatic reset_mid_drain(input int k);
    burst_q.push_back(k + 2);
    run = 1'b1; cyc(); run = 1'b0;
    for (int j = 1; j <= k; j++) begin
      halt = (j == k); cyc();
    end
    halt = 1'b0; cyc();
    rst = 1'b1; run = 1'b1; cyc(); rst = 1'b0; run = 1'b0;
    m_count = '0; m_halted = 1'b0; m_pend = 1'b0;
    check("rst_valid", o_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    idle_checks("rst_mid");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0; abort = 1'b0; clr = 1'b0; halt = 1'b0;
    m_count = '0; m_halted = 1'b0; m_pend = 1'b0; m_left = 0;
    repeat (3) cyc();
    rst = 1'b0;
    mon_en = 1'b1;
    check("reset_valid", o_valid, 1'b0);
    check("reset_busy", o_busy, 1'b0);
    check("reset_done", o_done, 1'b0);
    idle_checks("reset");

    // Directed scenarios.
    run_job(10, 1'b0);               // count 14, halted
    blocked_cmds();
    clear_cmd(1'b0);
    repeat (3) step_once(1'b0);      // count 3
    clear_cmd(1'b0);
    step_once(1'b1);
    repeat (4) step_once(1'b0);      // done after 5th step, count 5
    step_once(1'b0);                 // ignored while halted
    clear_cmd(1'b0);
    abort_run(6);                    // count 6, not halted
    clear_cmd(1'b0);
    priority_test();
    run_job(3, 1'b1);                // run+step -> RUN
    clear_cmd(1'b0);
    reset_mid_drain(4);
    run_job(2, 1'b0);                // run accepted after reset
    clear_cmd(1'b1);                 // clear wins over run

    // Randomized episodes.
    for (int it = 0; it < 40; it++) begin
      int r;
      r = int'($urandom_range(0, 4));
      if (m_halted) begin
        if (r < 2) blocked_cmds();
        else clear_cmd(1'($urandom_range(0, 1)));
      end else if (m_pend) begin
        step_once(1'($urandom_range(0, 1)));
      end else begin
        case (r)
          0: run_job(int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)));
          1: step_once($urandom_range(0, 3) == 0);
          2: abort_run(int'($urandom_range(1, 8)));
          3: clear_cmd(1'($urandom_range(0, 1)));
          default: priority_test();
        endcase
      end
    end

    repeat (4) cyc();
    check("done_queue_empty", exp_q.size(), 0);
    check("burst_queue_empty", burst_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
